// File: rtl/mux_scan_ctrl_if.sv
// Scan controller bus: request handshake, mux select/sample path
// and snapshot/status back to the controller.
interface mux_scan_ctrl_if #(
    parameter int DWELL_W = 4
);
    logic               start;
    logic               stop;
    logic [3:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic               f;
    logic               sel0;
    logic               sel1;
    logic               sample_valid;
    logic [1:0]         sample_ch;
    logic [3:0]         snapshot;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, mask, dwell, f,
        input  sel0, sel1, sample_valid, sample_ch,
        input  snapshot, busy, done
    );

    modport slave (
        input  start, stop, mask, dwell, f,
        output sel0, sel1, sample_valid, sample_ch,
        output snapshot, busy, done
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Masked round-robin scan of a 4:1 mux with per-channel dwell,
// sampling f into a 4-bit snapshot.
module mux_scan_ctrl #(
    parameter int DWELL_W = 4
) (
    input logic            clk,
    input logic            rst_n,
    mux_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [3:0]         mask_q, mask_d;
    logic [3:0]         snap_q, snap_d;
    logic [1:0]         first_ch;
    logic [1:0]         next_ch;
    logic               next_ok;
    logic               valid_c;
    logic [1:0]         ch_c;
    logic               done_c;

    // Descending loops leave the lowest qualifying index as the winner.
    always_comb begin
        first_ch = '0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.mask[i]) first_ch = 2'(i);
        end
    end

    always_comb begin
        next_ch = '0;
        next_ok = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i] && i > int'(sel_q)) begin
                next_ch = 2'(i);
                next_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        snap_d  = snap_q;
        valid_c = 1'b0;
        ch_c    = '0;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.stop && bus.start) begin
                    mask_d  = bus.mask;
                    dwell_d = bus.dwell;
                    if (bus.mask != 4'd0) begin
                        state_d = SCAN;
                        sel_d   = first_ch;
                        cnt_d   = bus.dwell;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SCAN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    valid_c        = 1'b1;
                    ch_c           = sel_q;
                    snap_d[sel_q]  = bus.f;
                    if (next_ok) begin
                        sel_d = next_ch;
                        cnt_d = dwell_q;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_c  = !bus.stop;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            snap_q  <= snap_d;
        end
    end

    assign bus.sel0         = sel_q[0];
    assign bus.sel1         = sel_q[1];
    assign bus.sample_valid = valid_c;
    assign bus.sample_ch    = ch_c;
    assign bus.snapshot     = snap_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_c;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: randomized scans checked
// against a channel-list timing model.
module tb_mux_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_v = 4'd0;
    int         cyc = 0;
    int         n_run = 0;
    int         n_fail = 0;
    logic [3:0] snap_m;
    logic [1:0] sel_m;

    typedef struct {
        bit is_done;
        int ch;
        int val;
        int cyc;
    } ev_t;

    ev_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux_scan_ctrl_if #(.DWELL_W(4)) bus ();

    mux_scan_ctrl #(.DWELL_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // The 4:1 mux the controller sits in front of.
    assign bus.f = in_v[{bus.sel1, bus.sel0}];

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_sel"}, int'({bus.sel1, bus.sel0}), 0);
        chk({tag, "_snapshot"}, int'(bus.snapshot), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_valid"}, int'(bus.sample_valid), 0);
    endtask

    task automatic run_scan(input logic [3:0] m, input int d,
                            input logic [3:0] iv, input int stop_at,
                            input int restart_at, input int rst_at);
        int ch_list[$];
        int n, total, c0, bc, off;
        bit ended;
        logic [1:0] sel_exp;
        for (int i = 0; i < 4; i++) if (m[i]) ch_list.push_back(i);
        n = ch_list.size();
        total = n * (d + 1);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.stop  = 1'b0;
        bus.mask  = m;
        bus.dwell = 4'(d);
        in_v      = iv;
        c0        = cyc;
        for (int k = 0; k < n; k++) begin
            off = (k + 1) * (d + 1);
            if (stop_at == 0 || off < stop_at) begin
                exp_q.push_back('{0, ch_list[k], int'(iv[ch_list[k]]), c0 + off});
                snap_m[ch_list[k]] = iv[ch_list[k]];
            end
        end
        if (stop_at == 0) exp_q.push_back('{1, 0, 0, c0 + total + 1});
        if (n == 0) sel_exp = sel_m;
        else if (stop_at == 0 || stop_at > total) sel_exp = 2'(ch_list[n-1]);
        else sel_exp = 2'(ch_list[(stop_at - 1) / (d + 1)]);
        bc = 0;
        ended = 0;
        for (int j = 1; j <= 200; j++) begin
            @(posedge clk);
            #1;
            bus.start = (j == restart_at);
            bus.mask  = 4'($urandom);
            bus.dwell = 4'($urandom);
            bus.stop  = (j == stop_at);
            if (j == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outs("async_reset");
                exp_q.delete();
                snap_m    = '0;
                sel_m     = '0;
                bus.start = 1'b0;
                bus.stop  = 1'b0;
                #2;
                rst_n = 1'b1;
                return;
            end
            if (!bus.busy) begin
                ended = 1;
                break;
            end
            bc++;
        end
        chk("scan_ended", int'(ended), 1);
        chk("busy_cycles", bc, (stop_at != 0) ? stop_at : total + 1);
        chk("events_left", exp_q.size(), 0);
        exp_q.delete();
        chk("snapshot", int'(bus.snapshot), int'(snap_m));
        chk("sel_final", int'({bus.sel1, bus.sel0}), int'(sel_exp));
        chk("done_idle", int'(bus.done), 0);
        sel_m = sel_exp;
    endtask

    initial begin
        logic [3:0] m;
        int d, tot, sa, ra;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mask  = '0;
        bus.dwell = '0;
        snap_m    = '0;
        sel_m     = '0;
        fork
            begin
                ev_t e;
                forever begin
                    @(negedge clk);
                    if (rst_n && (bus.sample_valid || bus.done)) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_event", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("event_kind", int'(bus.done), int'(e.is_done));
                            chk("event_cycle", cyc, e.cyc);
                            if (!e.is_done) begin
                                chk("sample_ch", int'(bus.sample_ch), e.ch);
                                chk("sample_f", int'(bus.f), e.val);
                                chk("ch_vs_sel", int'({bus.sel1, bus.sel0}), e.ch);
                            end
                        end
                    end
                end
            end
        join_none
        #12;
        chk_reset_outs("reset");
        rst_n = 1'b1;
        run_scan(4'b1111, 0, 4'b1101, 0, 0, 0);
        run_scan(4'b1010, 2, 4'b0110, 0, 0, 0);
        run_scan(4'b0000, 5, 4'($urandom), 0, 0, 0);
        run_scan(4'b1111, 3, 4'($urandom), 6, 0, 0);
        run_scan(4'b1111, 1, 4'($urandom), 0, 4, 0);
        run_scan(4'b1111, 3, 4'($urandom), 0, 3, 7);
        run_scan(4'b1011, 1, 4'($urandom), 0, 0, 0);
        run_scan(4'b0101, 15, 4'($urandom), 0, 0, 0);
        for (int t = 0; t < 40; t++) begin
            m   = 4'($urandom);
            d   = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
            tot = $countones(m) * (d + 1);
            sa  = 0;
            if (m != 0 && $urandom_range(0, 3) == 0)
                sa = int'($urandom_range(1, tot + 1));
            ra = 0;
            if ($urandom_range(0, 1) == 1) begin
                if (sa != 0 && sa >= 2) ra = int'($urandom_range(2, sa));
                else if (sa == 0 && tot >= 1) ra = int'($urandom_range(2, tot + 1));
            end
            run_scan(m, d, 4'($urandom), sa, ra, 0);
        end
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencing stage directly upstream of the 4:1 single-bit mux.
- Drives the mux selects sel1/sel0 through a masked round-robin scan and holds each channel for a programmable dwell.
- Samples the mux output f back into a 4-bit snapshot register.
- Provides a start/done handshake, so a controller can grab all four mux inputs as one word.

Parameters:
- DWELL_W, 4, width of the dwell (settle) count per channel.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a scan; honoured only in IDLE.
- stop  input  1  abort the current scan; takes priority over all other events.
- mask  input  4  channel enable, bit i = mux input i; latched when start is accepted.
- dwell  input  DWELL_W  extra settle cycles per channel; latched when start is accepted.
- f  input  1  mux output being sampled.
- sel0  output  1  mux select LSB, registered.
- sel1  output  1  mux select MSB, registered.
- sample_valid  output  1  one-cycle pulse when f is captured.
- sample_ch  output  2  channel index captured with sample_valid, equal to {sel1,sel0} on that cycle.
- snapshot  output  4  captured values; bit i = last captured f for channel i.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse at completion of a full scan.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - sel1, sel0, sample_valid, sample_ch, snapshot, busy and done are all 0.
  - Internal mask, dwell and counter registers are 0.
- States: IDLE, SCAN, DONE.
- IDLE -> SCAN on start=1 and latched mask!=0.
  - {sel1,sel0} is set to the lowest set mask bit.
  - The counter is loaded with dwell.
- IDLE -> DONE on start=1 and mask==0: no capture, snapshot unchanged.
- SCAN, each cycle:
  - If counter!=0, decrement it.
  - If counter==0:
    - Capture f into snapshot[{sel1,sel0}].
    - Pulse sample_valid with sample_ch={sel1,sel0}.
    - Advance sel to the next higher set mask bit and reload the counter with dwell.
    - If no higher set bit remains, go to DONE instead; sel holds the last channel.
- Per-channel timing:
  - Each channel is selected for dwell+1 cycles.
  - Capture happens on the last of those cycles, so f always has at least one full cycle after sel changes.
  - Total scan length = (popcount(mask) x (dwell+1)) cycles in SCAN, plus 1 cycle in DONE.
- Masked-off channels are skipped entirely. sel never visits them and their snapshot bits retain prior values.
- DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
- busy=1 in SCAN and DONE, and 0 in IDLE.
- start while busy is ignored; mask/dwell changes during a scan have no effect.
- stop=1 in SCAN or DONE:
  - Next state is IDLE with no done pulse.
  - No capture occurs that cycle, even if counter==0.
  - snapshot keeps bits already captured.
  - sel holds its current value.
- stop=1 together with start in IDLE: stop wins, remain IDLE.
- dwell wraps nothing: the counter only counts down from the latched value, and a maximum dwell of 2^DWELL_W-1 is legal.
- Reset asserted mid-scan returns all outputs to reset values immediately (asynchronous), including clearing snapshot.
- sel0/sel1 change only on clk rising edges and are glitch-free registered outputs.

Test Plan:
- Full scan:
  - Stimulus: mask=4'b1111, dwell=0, inputs in0..in3=1,0,1,1, start pulse.
  - Required: sel sequence 00,01,10,11 on consecutive cycles, 4 sample_valid pulses with sample_ch 0..3, snapshot=4'b1101, done 1 cycle after the last capture, busy high for 5 cycles.
- Sparse mask with dwell:
  - Stimulus: mask=4'b1010, dwell=2, in1=1, in3=0.
  - Required: sel=01 for 3 cycles then 11 for 3 cycles, captures at cycles 3 and 6 of SCAN, snapshot bit1=1, bit3=0, bits 0 and 2 unchanged from prior value.
- Empty mask:
  - Stimulus: mask=0, start.
  - Required: busy and done high for exactly one cycle, no sample_valid, sel and snapshot unchanged.
- Abort:
  - Stimulus: mask=4'b1111, dwell=3, stop asserted on the 6th SCAN cycle.
  - Required: one capture (channel 0) only, returns to IDLE, done never pulses, sel holds 01.
- Start while busy plus async reset:
  - Stimulus: re-pulse start mid-scan.
  - Required: scan length unchanged.
  - Then drop rst_n mid-scan: sel, snapshot, busy and done go to 0 without a clock edge; a fresh start after release scans normally.
